// File: rtl/cordic_par_issuer_pkg.sv
// Shared definitions for the CORDIC pipeline issuer.
// Holds the width helper used for FIFO pointers and the occupancy counter.
package cordic_par_issuer_pkg;

    function automatic int ceil_log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cordic_issuer_fifo.sv
// Show-ahead result FIFO; the head entry is always on rdata_o.
// Entries become visible the cycle after they are written.
module cordic_issuer_fifo
    import cordic_par_issuer_pkg::*;
#(
    parameter int W     = 48,
    parameter int DEPTH = 32,
    localparam int PW   = ceil_log2(DEPTH)
) (
    input  logic         clk,
    input  logic         nGrst,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic [PW:0]  count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW:0]   count_q, count_d;
    logic          pop_ok;

    always_comb begin
        pop_ok  = pop_i && (count_q != '0);
        wr_d    = wr_q + PW'(push_i);
        rd_d    = rd_q + PW'(pop_ok);
        count_d = count_q + (PW+1)'(push_i) - (PW+1)'(pop_ok);
    end

    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/cordic_par_issuer.sv
// Credit-based issuer for a fixed-latency, non-stallable CORDIC pipeline.
// Issues requests, tracks expected results and buffers them in order.
module cordic_par_issuer
    import cordic_par_issuer_pkg::*;
#(
    parameter int IN_BITS    = 16,
    parameter int OUT_BITS   = 16,
    parameter int LATENCY    = 28,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                clk,
    input  logic                nGrst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [IN_BITS-1:0]  req_x,
    input  logic [IN_BITS-1:0]  req_y,
    input  logic [IN_BITS-1:0]  req_a,
    output logic                cdc_valid,
    output logic [IN_BITS-1:0]  cdc_x,
    output logic [IN_BITS-1:0]  cdc_y,
    output logic [IN_BITS-1:0]  cdc_a,
    input  logic                cdc_dout_valid,
    input  logic [OUT_BITS-1:0] cdc_out_x,
    input  logic [OUT_BITS-1:0] cdc_out_y,
    input  logic [OUT_BITS-1:0] cdc_out_a,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [OUT_BITS-1:0] res_x,
    output logic [OUT_BITS-1:0] res_y,
    output logic [OUT_BITS-1:0] res_a,
    input  logic                clr_err,
    output logic                err_missing,
    output logic                err_unexpected
);

    localparam int PW    = ceil_log2(FIFO_DEPTH);
    localparam int OCC_W = PW + 1;
    localparam int DW    = 3 * OUT_BITS;

    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [LATENCY-1:0] exp_q, exp_d;
    logic               cdc_valid_q;
    logic [IN_BITS-1:0] cdc_x_q, cdc_y_q, cdc_a_q;
    logic               err_miss_q, err_miss_d;
    logic               err_unex_q, err_unex_d;
    logic               accept, pop, due, miss, unex, push;
    logic [DW-1:0]      fifo_rdata;
    logic [PW:0]        fifo_count;

    always_comb begin
        req_ready  = occ_q < OCC_W'(FIFO_DEPTH);
        accept     = req_valid && req_ready;
        res_valid  = fifo_count != '0;
        pop        = res_valid && res_ready;
        due        = exp_q[LATENCY-1];
        push       = due && cdc_dout_valid;
        miss       = due && !cdc_dout_valid;
        unex       = !due && cdc_dout_valid;
        occ_d      = occ_q + OCC_W'(accept) - OCC_W'(pop) - OCC_W'(miss);
        exp_d      = {exp_q[LATENCY-2:0], cdc_valid_q};
        // A new event wins over a simultaneous clear.
        err_miss_d = (clr_err ? 1'b0 : err_miss_q) || miss;
        err_unex_d = (clr_err ? 1'b0 : err_unex_q) || unex;
    end

    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            occ_q       <= '0;
            exp_q       <= '0;
            cdc_valid_q <= 1'b0;
            cdc_x_q     <= '0;
            cdc_y_q     <= '0;
            cdc_a_q     <= '0;
            err_miss_q  <= 1'b0;
            err_unex_q  <= 1'b0;
        end else begin
            occ_q       <= occ_d;
            exp_q       <= exp_d;
            cdc_valid_q <= accept;
            err_miss_q  <= err_miss_d;
            err_unex_q  <= err_unex_d;
            if (accept) begin
                cdc_x_q <= req_x;
                cdc_y_q <= req_y;
                cdc_a_q <= req_a;
            end
        end
    end

    cordic_issuer_fifo #(
        .W     (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .nGrst   (nGrst),
        .push_i  (push),
        .wdata_i ({cdc_out_x, cdc_out_y, cdc_out_a}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    assign cdc_valid      = cdc_valid_q;
    assign cdc_x          = cdc_x_q;
    assign cdc_y          = cdc_y_q;
    assign cdc_a          = cdc_a_q;
    assign res_x          = fifo_rdata[DW-1 -: OUT_BITS];
    assign res_y          = fifo_rdata[OUT_BITS +: OUT_BITS];
    assign res_a          = fifo_rdata[OUT_BITS-1:0];
    assign err_missing    = err_miss_q;
    assign err_unexpected = err_unex_q;

endmodule

// File: tb/tb_cordic_par_issuer.sv
// Scoreboard bench for cordic_par_issuer with a fixed-latency CORDIC model.
// Expected results are queued on accept and compared on pop.
module tb_cordic_par_issuer;

    localparam int L = 28;

    logic        clk = 1'b0;
    logic        nGrst;
    logic        req_valid, req_ready;
    logic [15:0] req_x, req_y, req_a;
    logic        cdc_valid;
    logic [15:0] cdc_x, cdc_y, cdc_a;
    logic        cdc_dout_valid;
    logic [15:0] cdc_out_x, cdc_out_y, cdc_out_a;
    logic        res_valid, res_ready;
    logic [15:0] res_x, res_y, res_a;
    logic        clr_err, err_missing, err_unexpected;

    int checks = 0;
    int errors = 0;
    int n_acc = 0;
    int n_pop = 0;
    logic [47:0] sbq [$];
    logic skip = 1'b0;
    logic kill = 1'b0;
    logic spur = 1'b0;

    bit        mv [L];
    bit [47:0] md [L];

    always #5 clk = ~clk;

    cordic_par_issuer dut (
        .clk(clk), .nGrst(nGrst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_a(req_a),
        .cdc_valid(cdc_valid),
        .cdc_x(cdc_x), .cdc_y(cdc_y), .cdc_a(cdc_a),
        .cdc_dout_valid(cdc_dout_valid),
        .cdc_out_x(cdc_out_x), .cdc_out_y(cdc_out_y),
        .cdc_out_a(cdc_out_a),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_x(res_x), .res_y(res_y), .res_a(res_a),
        .clr_err(clr_err), .err_missing(err_missing),
        .err_unexpected(err_unexpected)
    );

    function automatic logic [47:0] f(
        input logic [15:0] x, input logic [15:0] y, input logic [15:0] a);
        logic [15:0] ox, oy, oa;
        ox = x + a;
        oy = y ^ 16'h5a5a;
        oa = a - x;
        return {ox, oy, oa};
    endfunction

    // Fixed-latency CORDIC model; kill drops the issue seen this cycle.
    always @(posedge clk) begin
        for (int i = L - 1; i > 0; i--) begin
            mv[i] <= mv[i-1];
            md[i] <= md[i-1];
        end
        mv[0] <= cdc_valid && !kill;
        md[0] <= f(cdc_x, cdc_y, cdc_a);
    end

    assign cdc_dout_valid = mv[L-1] || spur;
    assign {cdc_out_x, cdc_out_y, cdc_out_a} = md[L-1];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (nGrst && req_valid && req_ready) begin
            n_acc++;
            if (!skip) sbq.push_back(f(req_x, req_y, req_a));
        end
        if (nGrst && res_valid && res_ready) begin
            n_pop++;
            if (sbq.size() == 0) chk("extra_pop", res_valid, 1'b0);
            else chk("res_data", {res_x, res_y, res_a}, sbq.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_req();
        req_x = 16'($urandom);
        req_y = 16'($urandom);
        req_a = 16'($urandom);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        res_ready = 1'b1;
        while ((sbq.size() != 0 || res_valid) && k < 300) begin
            tick();
            k++;
        end
        chk(tag, sbq.size(), 0);
    endtask

    task automatic fill_check(input string tag);
        int a0;
        a0 = n_acc;
        res_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rnd_req();
            tick();
        end
        req_valid = 1'b0;
        chk({tag, "_acc"}, n_acc - a0, 32);
        chk({tag, "_rdy0"}, req_ready, 1'b0);
    endtask

    initial begin
        int n, a0, p0;
        nGrst = 1'b0;
        req_valid = 1'b0;
        req_x = '0; req_y = '0; req_a = '0;
        res_ready = 1'b0;
        clr_err = 1'b0;
        tick();
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_rvalid", res_valid, 1'b0);
        chk("rst_cvalid", cdc_valid, 1'b0);
        chk("rst_errs", {err_missing, err_unexpected}, 2'b00);
        tick();
        nGrst = 1'b1;
        tick();

        // Single request latency.
        res_ready = 1'b1;
        req_valid = 1'b1;
        req_x = 16'h4000; req_y = 16'h0000; req_a = 16'h2000;
        tick();
        req_valid = 1'b0;
        chk("cdc_valid", cdc_valid, 1'b1);
        chk("cdc_data", {cdc_x, cdc_y, cdc_a}, 48'h4000_0000_2000);
        tick();
        chk("cdc_pulse", cdc_valid, 1'b0);
        n = 2;
        while (!res_valid && n < 100) begin
            tick();
            n++;
        end
        chk("latency", n, 30);
        chk("res_single", {res_x, res_y, res_a}, 48'h6000_5a5a_e000);
        drain("drain1");

        // Backpressure: fill the credits, then release one.
        fill_check("fill");
        repeat (35) tick();
        chk("full_rdy", req_ready, 1'b0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("one_pop_rdy", req_ready, 1'b1);
        drain("drain2");

        // Full throughput.
        a0 = n_acc;
        p0 = n_pop;
        res_ready = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            rnd_req();
            tick();
        end
        req_valid = 1'b0;
        chk("thru_acc", n_acc - a0, 200);
        chk("thru_occ", dut.occ_q, 30);
        drain("drain3");
        chk("thru_pop", n_pop - p0, 200);

        // Missing result.
        req_valid = 1'b1;
        skip = 1'b1;
        rnd_req();
        tick();
        req_valid = 1'b0;
        skip = 1'b0;
        kill = 1'b1;
        tick();
        kill = 1'b0;
        n = 2;
        while (!err_missing && n < 100) begin
            tick();
            n++;
        end
        chk("miss_time", n, 30);
        chk("miss_occ", dut.occ_q, 0);
        fill_check("refill");
        drain("drain4");
        chk("miss_sticky", err_missing, 1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("miss_clr", err_missing, 1'b0);

        // Spurious result.
        spur = 1'b1;
        tick();
        spur = 1'b0;
        chk("unex_set", err_unexpected, 1'b1);
        chk("unex_cnt", dut.u_fifo.count_q, 0);
        chk("unex_rv", res_valid, 1'b0);
        clr_err = 1'b1;
        spur = 1'b1;
        tick();
        spur = 1'b0;
        clr_err = 1'b0;
        chk("unex_clr_race", err_unexpected, 1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("unex_clr", err_unexpected, 1'b0);

        // Reset with work in flight.
        res_ready = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rnd_req();
            tick();
        end
        req_valid = 1'b0;
        repeat (5) tick();
        nGrst = 1'b0;
        sbq.delete();
        #2;
        chk("mid_rst_rdy", req_ready, 1'b1);
        chk("mid_rst_rv", res_valid, 1'b0);
        chk("mid_rst_err", {err_missing, err_unexpected}, 2'b00);
        tick();
        nGrst = 1'b1;
        repeat (40) tick();
        chk("late_unex", err_unexpected, 1'b1);
        chk("late_rv", res_valid, 1'b0);
        chk("late_cnt", dut.u_fifo.count_q, 0);
        chk("late_occ", dut.occ_q, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_par_issuer.md
CORDIC_PAR_ISSUER -- requirements
Module: cordic_par_issuer

Interface
REQ-001 SHALL have parameters: IN_BITS, default 16, CORDIC input word width; OUT_BITS, default 16, CORDIC output word width; LATENCY, default 28, cycles from CORDIC din_valid to dout_valid, at least 2; FIFO_DEPTH, default 32, result FIFO entries, power of 2, at least 2.
REQ-002 SHALL have ports, one per line:
  clk  in  1  single clock, rising edge
  nGrst  in  1  asynchronous active-low reset
  req_valid  in  1  upstream request valid
  req_ready  out  1  upstream request accepted when high with req_valid
  req_x, req_y, req_a  in  IN_BITS each  request operands
  cdc_valid  out  1  CORDIC din_valid
  cdc_x, cdc_y, cdc_a  out  IN_BITS each  CORDIC din_x/din_y/din_a
  cdc_dout_valid  in  1  CORDIC dout_valid
  cdc_out_x, cdc_out_y, cdc_out_a  in  OUT_BITS each  CORDIC results
  res_valid  out  1  result available
  res_ready  in  1  downstream accepts result
  res_x, res_y, res_a  out  OUT_BITS each  result data
  clr_err  in  1  synchronous clear of the error flags
  err_missing  out  1  sticky: an expected result did not arrive
  err_unexpected  out  1  sticky: a result arrived with no issue pending

Function
REQ-003 SHALL be the initiator for the fixed-latency, non-stallable CORDIC pipeline; it SHALL add credit-based backpressure toward both the upstream and downstream sides.
REQ-004 SHALL hold an occupancy counter occ, 0..FIFO_DEPTH, that counts accepted requests not yet popped from the result FIFO.
REQ-005 SHALL drive req_ready = (occ < FIFO_DEPTH); req_ready SHALL come only from registered state and SHALL NOT depend combinationally on req_valid.
REQ-006 On accept (req_valid & req_ready), SHALL register req_x/y/a into cdc_x/y/a and SHALL assert cdc_valid for exactly the next cycle.
REQ-007 SHALL hold cdc_x/y/a at their last values when no request is issued.
REQ-008 SHALL update occ as follows: +1 on accept; -1 on pop (res_valid & res_ready); -1 on each err_missing event; these changes SHALL combine arithmetically when they occur in the same cycle.
REQ-009 SHALL keep an expectation shift register of LATENCY bits; cdc_valid SHALL shift in at bit 0; the bit at index LATENCY-1 SHALL mark the cycle in which a result is due.
REQ-010 If a result is due and cdc_dout_valid=1, SHALL write cdc_out_x/y/a into the result FIFO.
REQ-011 If a result is due and cdc_dout_valid=0, SHALL set err_missing and SHALL write nothing to the FIFO.
REQ-012 If cdc_dout_valid=1 and no result is due, SHALL set err_unexpected and SHALL drop the data.
REQ-013 The result FIFO SHALL be show-ahead: res_valid = (count != 0), and res_x/y/a SHALL present the head entry.
REQ-014 The FIFO SHALL have no write-to-read bypass: an entry written into an empty FIFO SHALL appear at the outputs on the next cycle.
REQ-015 End-to-end latency from accept to res_valid, with the FIFO empty, SHALL be LATENCY+2 cycles.
REQ-016 The FIFO SHALL accept a push and a pop in the same cycle at any fill level, including full; overflow is impossible by construction of the credits.
REQ-017 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 Error flags SHALL be sticky until clr_err=1.
REQ-019 If clr_err and a new error event occur in the same cycle, the flag SHALL end the cycle set.
REQ-020 In-order delivery SHALL be guaranteed: result n on the res_* outputs corresponds to accepted request n.

Reset
REQ-021 On nGrst=0, asynchronously, SHALL clear occ, the FIFO pointers and count, the expectation register, cdc_valid, cdc_x/y/a, err_missing and err_unexpected; consequently res_valid=0 and req_ready=1.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight and stored results.
REQ-023 CORDIC results that arrive after reset release SHALL be flagged as err_unexpected and dropped, not delivered.

Structure
REQ-024 The shared package SHALL hold a function computing the ceiling of log2, used for pointer width and occ width; occ SHALL be ceil_log2(FIFO_DEPTH)+1 bits wide.
REQ-025 SHALL contain one sub-module, cordic_issuer_fifo: a synchronous show-ahead FIFO of width 3*OUT_BITS, with depth FIFO_DEPTH, asynchronous active-low reset, and push/pop/count ports.
REQ-026 Issue logic, occupancy counter and expectation monitor SHALL sit in the top module.

Verification
REQ-027 Single request x=0x4000, y=0, a=0x2000 with a LATENCY-delay CORDIC model -> cdc_valid one cycle after accept; res_valid exactly 30 cycles after accept (LATENCY=28); res_x/y/a equal the model outputs.
REQ-028 res_ready held 0, requests streamed continuously -> exactly 32 accepts, then req_ready=0; one pop -> req_ready=1 on the next cycle; no data loss; order preserved.
REQ-029 Full throughput, req_valid=res_ready=1 for 200 cycles -> one accept per cycle; occ settles at 30; 200 results delivered in order.
REQ-030 Model suppresses one dout_valid -> err_missing=1 from the next cycle; occ is restored, so 32 accepts remain possible after draining; clr_err -> flag returns to 0.
REQ-031 Spurious cdc_dout_valid with no issue pending -> err_unexpected=1, FIFO count unchanged; simultaneous clr_err with a new spurious event -> flag remains 1.
REQ-032 nGrst pulsed with 10 requests in flight -> req_ready=1, res_valid=0, both error flags 0; late model outputs raise err_unexpected and are not delivered.
